// File: rtl/fifo_pkg.sv
// Shared sizing helpers, parameter legality checks and status types for the
// parametrised synchronous FIFO and its storage.
package fifo_pkg;

    // Ceiling log2: clog2(1) = 0, clog2(8) = 3, clog2(9) = 4.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem    = (value > 0) ? value - 1 : 0;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // True when value is a non-zero power of two.
    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

    // Pointer width: addresses 0..DEPTH-1 and wraps naturally.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return clog2(depth);
    endfunction

    // Occupancy width: must represent 0..DEPTH inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return clog2(depth + 1);
    endfunction

    // Legal configuration: power-of-two depth of at least 2 and
    // AE_LEVEL < AF_LEVEL <= DEPTH.
    function automatic bit params_ok(input int unsigned data_width,
                                     input int unsigned depth,
                                     input int unsigned af_level,
                                     input int unsigned ae_level);
        return (data_width >= 1) && (depth >= 2) && is_pow2(depth) &&
               (af_level >= 1) && (af_level <= depth) &&
               (ae_level < af_level);
    endfunction

    // Occupancy-derived status flags, all registered together with count.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } status_t;

    // Sticky error flags.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_t;

    localparam status_t STATUS_RESET = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

    localparam err_t ERR_RESET = '{overflow: 1'b0, underflow: 1'b0};

endpackage : fifo_pkg

// File: rtl/dpram_sclk.sv
// Simple single-clock dual-port RAM: one write port, one read port with a
// registered read data output. A read and write to the same address in the
// same cycle returns the old contents.
module dpram_sclk
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        we,
    input  logic [clog2(DEPTH)-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic                        re,
    input  logic [clog2(DEPTH)-1:0]     raddr,
    output logic [DATA_WIDTH-1:0]       rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage write port.
    // NOTE: the array has no reset on purpose; resetting it would turn a RAM
    // into a flop bank, and its contents are unobservable until written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value when no read is requested.
    // NOTE: non-blocking assignment here is what makes a same-address
    // read/write return the old entry; a blocking write would race it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule : dpram_sclk

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO controller. Owns a dual-port RAM, accepts
// simultaneous push/pop, and registers occupancy, threshold flags and sticky
// error flags so that no input reaches an output combinationally.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AF_LEVEL   = 6,
    parameter int unsigned AE_LEVEL   = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic                            pop,
    input  logic                            err_clr,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            valid_out,
    output logic [count_width(DEPTH)-1:0]   count,
    output logic                            full,
    output logic                            empty,
    output logic                            almost_full,
    output logic                            almost_empty,
    output logic                            overflow,
    output logic                            underflow
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = count_width(DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

    // Reject illegal configurations at elaboration.
    if (!params_ok(DATA_WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("fifo_sync_param: DEPTH must be a power of two >= 2 and AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    status_t          status_q, status_d;
    err_t             err_q,    err_d;
    logic             valid_q,  valid_d;

    logic             push_ok;
    logic             pop_ok;

    // Acceptance is judged on the registered (pre-edge) state only. A full
    // FIFO still accepts a push when a pop frees an entry in the same cycle.
    always_comb begin
        pop_ok  = pop & ~status_q.empty;
        push_ok = push & (~status_q.full | pop_ok);
    end

    // Next pointers, occupancy and read-valid pulse.
    // NOTE: every output of this block is given a default first so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = pop_ok;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Status flags derived from the next count so they line up with count.
    always_comb begin
        status_d              = status_q;
        status_d.full         = (count_d == DEPTH_C);
        status_d.empty        = (count_d == '0);
        status_d.almost_full  = (count_d >= AF_C);
        status_d.almost_empty = (count_d <= AE_C);
    end

    // Sticky errors: a new error in the same cycle as err_clr keeps the flag.
    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = ERR_RESET;
        end
        if (push & ~push_ok) begin
            err_d.overflow = 1'b1;
        end
        if (pop & status_q.empty) begin
            err_d.underflow = 1'b1;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            status_q <= STATUS_RESET;
            err_q    <= ERR_RESET;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            status_q <= status_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
        end
    end

    dpram_sclk #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .re    (pop_ok),
        .raddr (rd_ptr_q),
        .rdata (data_out)
    );

    assign valid_out    = valid_q;
    assign count        = count_q;
    assign full         = status_q.full;
    assign empty        = status_q.empty;
    assign almost_full  = status_q.almost_full;
    assign almost_empty = status_q.almost_empty;
    assign overflow     = err_q.overflow;
    assign underflow    = err_q.underflow;

endmodule : fifo_sync_param
